// File: rtl/abs_pkg.sv
// Shared defaults and types for the absolute-value unit.
package abs_pkg;

  localparam int ABS_WIDTH_DEF    = 8;
  localparam bit ABS_SATURATE_DEF = 1'b1;

  // Operand classes that select how the magnitude is formed.
  typedef enum logic [1:0] {
    MAG_POS = 2'd0,
    MAG_NEG = 2'd1,
    MAG_MIN = 2'd2
  } mag_class_e;

endpackage

// File: rtl/abs_core.sv
// Combinational magnitude, sign and most-negative detection for one operand.
module abs_core
  import abs_pkg::*;
#(
  parameter int WIDTH    = ABS_WIDTH_DEF,
  parameter bit SATURATE = ABS_SATURATE_DEF
) (
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-2:0] mag,
  output logic             is_min,
  output logic             sign
);

  localparam logic signed [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [WIDTH-1:0] value_s;
  logic signed [WIDTH-1:0] negated;
  mag_class_e              cls;

  function automatic mag_class_e classify(input logic signed [WIDTH-1:0] v);
    if (!v[WIDTH-1])
      return MAG_POS;
    else if (v == MIN_VAL)
      return MAG_MIN;
    else
      return MAG_NEG;
  endfunction

  // The most-negative operand has no representable magnitude; clamp or wrap.
  function automatic logic [WIDTH-2:0] sat_mag();
    logic [WIDTH-2:0] m;
    m = SATURATE ? {(WIDTH-1){1'b1}} : {(WIDTH-1){1'b0}};
    return m;
  endfunction

  assign value_s = value;
  assign negated = '0 - value_s;

  always_comb begin
    cls    = classify(value_s);
    sign   = value_s[WIDTH-1];
    is_min = (cls == MAG_MIN);
    mag    = '0;
    case (cls)
      MAG_POS: mag = value_s[WIDTH-2:0];
      MAG_NEG: mag = negated[WIDTH-2:0];
      default: mag = sat_mag();
    endcase
  end

endmodule

// File: rtl/abs.sv
// Registered absolute-value unit: one output register stage plus valid.
module abs
  import abs_pkg::*;
#(
  parameter int WIDTH    = ABS_WIDTH_DEF,
  parameter bit SATURATE = ABS_SATURATE_DEF
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] signed_value,
  output logic [WIDTH-2:0] result,
  output logic             neg,
  output logic             ov,
  output logic             out_valid
);

  logic [WIDTH-2:0] mag_p0;
  logic             is_min_p0;
  logic             sign_p0;

  logic [WIDTH-2:0] result_p1;
  logic             neg_p1;
  logic             ov_p1;
  logic             vld_p1;

  abs_core #(
    .WIDTH   (WIDTH),
    .SATURATE(SATURATE)
  ) u_core (
    .value (signed_value),
    .mag   (mag_p0),
    .is_min(is_min_p0),
    .sign  (sign_p0)
  );

  // p0 -> p1: data registers update only on a valid operand and hold otherwise.
  always_ff @(posedge clk) begin
    if (Reset) begin
      result_p1 <= '0;
      neg_p1    <= 1'b0;
      ov_p1     <= 1'b0;
      vld_p1    <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        result_p1 <= mag_p0;
        neg_p1    <= sign_p0;
        ov_p1     <= is_min_p0;
      end
    end
  end

  assign result    = result_p1;
  assign neg       = neg_p1;
  assign ov        = ov_p1;
  assign out_valid = vld_p1;

endmodule

// File: tb/tb_abs.sv
// Bench for abs: directed vector table, full operand sweep and random stream.
module tb_abs;

  logic       clk;
  logic       Reset;
  logic       in_valid;
  logic [7:0] signed_value;
  logic [6:0] result,  result0;
  logic       neg,     neg0;
  logic       ov,      ov0;
  logic       out_valid, out_valid0;

  int errors = 0;
  int checks = 0;

  // Reference state, one copy per SATURATE setting for the magnitude.
  logic [6:0] m_res1, m_res0;
  logic       m_neg, m_ov, m_vld;

  abs #(.WIDTH(8), .SATURATE(1'b1)) dut (
    .clk(clk), .Reset(Reset), .in_valid(in_valid), .signed_value(signed_value),
    .result(result), .neg(neg), .ov(ov), .out_valid(out_valid)
  );

  abs #(.WIDTH(8), .SATURATE(1'b0)) dut0 (
    .clk(clk), .Reset(Reset), .in_valid(in_valid), .signed_value(signed_value),
    .result(result0), .neg(neg0), .ov(ov0), .out_valid(out_valid0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       iv;
    logic [7:0] val;
    logic [6:0] res;
    logic       neg;
    logic       ov;
    logic       vld;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic rst, input logic iv, input logic [7:0] v);
    int s;
    int m;
    if (rst) begin
      m_res1 = '0; m_res0 = '0; m_neg = 1'b0; m_ov = 1'b0; m_vld = 1'b0;
    end else begin
      m_vld = iv;
      if (iv) begin
        s     = int'($signed(v));
        m     = (s < 0) ? -s : s;
        m_neg = (s < 0);
        if (m > 127) begin
          m_ov = 1'b1; m_res1 = 7'h7F; m_res0 = 7'h00;
        end else begin
          m_ov = 1'b0; m_res1 = m[6:0]; m_res0 = m[6:0];
        end
      end
    end
  endtask

  task automatic step(input logic rst, input logic iv, input logic [7:0] v);
    @(negedge clk);
    Reset = rst; in_valid = iv; signed_value = v;
    @(posedge clk);
    model_step(rst, iv, v);
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".result"},     {25'd0, result},  {25'd0, m_res1});
    chk({tag, ".neg"},        {31'd0, neg},     {31'd0, m_neg});
    chk({tag, ".ov"},         {31'd0, ov},      {31'd0, m_ov});
    chk({tag, ".out_valid"},  {31'd0, out_valid}, {31'd0, m_vld});
    chk({tag, ".result_s0"},  {25'd0, result0}, {25'd0, m_res0});
    chk({tag, ".ov_s0"},      {31'd0, ov0},     {31'd0, m_ov});
  endtask

  vec_t vecs[$];

  initial begin
    Reset = 1'b1; in_valid = 1'b0; signed_value = 8'h00;
    m_res1 = '0; m_res0 = '0; m_neg = 1'b0; m_ov = 1'b0; m_vld = 1'b0;

    //            rst   iv    val    res    neg   ov    vld
    vecs.push_back('{1'b1, 1'b1, 8'h33, 7'h00, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 8'h33, 7'h00, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 8'h01, 7'h01, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 8'hFF, 7'h01, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 8'h81, 7'h7F, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 8'h7F, 7'h7F, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 8'h80, 7'h7F, 1'b1, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 8'h00, 7'h00, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 8'hFB, 7'h05, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 8'hx,  7'h05, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 8'h80, 7'h05, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 8'h90, 7'h70, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 1'b1, 8'h55, 7'h00, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 8'h10, 7'h10, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 8'h80, 7'h7F, 1'b1, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 8'h00, 7'h00, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 8'h80, 7'h7F, 1'b1, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 8'h00, 7'h00, 1'b0, 1'b0, 1'b1});

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].iv, vecs[i].val);
      chk($sformatf("vec%0d.result", i),    {25'd0, result},    {25'd0, vecs[i].res});
      chk($sformatf("vec%0d.neg", i),       {31'd0, neg},       {31'd0, vecs[i].neg});
      chk($sformatf("vec%0d.ov", i),        {31'd0, ov},        {31'd0, vecs[i].ov});
      chk($sformatf("vec%0d.out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].vld});
      chk($sformatf("vec%0d.result_s0", i), {25'd0, result0},   {25'd0, m_res0});
      chk($sformatf("vec%0d.ov_s0", i),     {31'd0, ov0},       {31'd0, m_ov});
    end

    // Wrap mode on the most-negative operand, checked against a constant.
    step(1'b0, 1'b1, 8'h80);
    chk("s0_min.result", {25'd0, result0}, 32'd0);
    chk("s0_min.ov",     {31'd0, ov0},     32'd1);

    // Full counter sweep, one operand per clock.
    for (int v = 0; v < 256; v++) begin
      step(1'b0, 1'b1, 8'(v));
      chk_model($sformatf("sweep%02h", v));
    end

    // Random stream with occasional resets and idle cycles.
    for (int n = 0; n < 400; n++) begin
      logic       r;
      logic       iv;
      logic [7:0] v;
      r  = ($urandom_range(0, 19) == 0);
      iv = ($urandom_range(0, 3) != 0);
      v  = 8'($urandom);
      step(r, iv, v);
      chk_model($sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
